// File: rtl/aes_128_key_expand_pkg.sv
// Shared definitions for the AES-128 key schedule generator.
//   NumRounds / LengthRam : default round count and key-RAM depth (64-bit words)
//   StIdle..StCalc        : FSM state encoding
//   rcon()                : round constant lookup, index 1..10
package aes_128_key_expand_pkg;

  localparam int unsigned NumRounds = 10;
  localparam int unsigned LengthRam = 2 * (NumRounds + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWrLo = 2'd1;
  localparam logic [1:0] StWrHi = 2'd2;
  localparam logic [1:0] StCalc = 2'd3;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_128_key_expand_sbox.sv
// AES forward S-box, purely combinational.
//   value : input byte
//   subst : substituted byte
module aes_128_key_expand_sbox (
  input  logic [7:0] value,
  output logic [7:0] subst
);

  localparam logic [7:0] SboxTable [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subst = SboxTable[value];

endmodule

// File: rtl/aes_128_key_expand.sv
// AES-128 key schedule generator: writes all round keys into the round-key RAM as
// 64-bit halves (low half first), then pulses key_done.
//   clk          : clock, everything on posedge
//   kill         : synchronous active-high reset
//   key_start    : 1-cycle request, honoured only when idle
//   key_in       : cipher key, byte i at bits [8i+7:8i]
//   en_wr        : RAM write strobe
//   addr_wr      : RAM write address
//   key_round_wr : RAM write data
//   key_busy     : expansion in progress
//   key_done     : 1-cycle pulse after the last write
module aes_128_key_expand
  import aes_128_key_expand_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NumRounds,
  parameter int unsigned LENGTH_RAM = LengthRam
) (
  input  logic         clk,
  input  logic         kill,
  input  logic         key_start,
  input  logic [127:0] key_in,
  output logic         en_wr,
  output logic [4:0]   addr_wr,
  output logic [63:0]  key_round_wr,
  output logic         key_busy,
  output logic         key_done
);

  localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
  localparam logic [4:0] LastAddr  = 5'(LENGTH_RAM - 1);

  logic [1:0]   state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;
  logic         en_wr_d, key_busy_d, key_done_d;
  logic [4:0]   addr_wr_d;
  logic [63:0]  key_round_wr_d;

  // SubWord(RotWord(w3)): lane i substitutes key byte 12 + ((i + 1) % 4).
  logic [7:0]   sub [4];
  logic [31:0]  temp;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [127:0] key_next;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_128_key_expand_sbox u_sbox (
      .value (key_q[96 + 8 * ((i + 1) % 4) +: 8]),
      .subst (sub[i])
    );
  end

  always_comb begin
    temp     = {sub[3], sub[2], sub[1], sub[0] ^ rcon(round_q + 4'd1)};
    w0_n     = key_q[31:0] ^ temp;
    w1_n     = key_q[63:32] ^ w0_n;
    w2_n     = key_q[95:64] ^ w1_n;
    w3_n     = key_q[127:96] ^ w2_n;
    key_next = {w3_n, w2_n, w1_n, w0_n};
  end

  // Output registers are loaded on the same edge as the state they belong to, so each
  // write appears in the cycle the FSM sits in WR_LO / WR_HI.
  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    key_d          = key_q;
    en_wr_d        = 1'b0;
    addr_wr_d      = addr_wr;
    key_round_wr_d = key_round_wr;
    key_busy_d     = key_busy;
    key_done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (key_start) begin
          key_d          = key_in;
          round_d        = 4'd0;
          state_d        = StWrLo;
          en_wr_d        = 1'b1;
          addr_wr_d      = 5'd0;
          key_round_wr_d = key_in[63:0];
          key_busy_d     = 1'b1;
        end
      end
      StWrLo: begin
        state_d        = StWrHi;
        en_wr_d        = 1'b1;
        addr_wr_d      = {round_q, 1'b1};
        key_round_wr_d = key_q[127:64];
      end
      StWrHi: begin
        // addr_wr holds the address being written in this cycle.
        if (round_q == LastRound || addr_wr == LastAddr) begin
          state_d    = StIdle;
          key_busy_d = 1'b0;
          key_done_d = 1'b1;
        end else begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        key_d          = key_next;
        round_d        = round_q + 4'd1;
        state_d        = StWrLo;
        en_wr_d        = 1'b1;
        addr_wr_d      = {round_q + 4'd1, 1'b0};
        key_round_wr_d = key_next[63:0];
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state_q      <= StIdle;
      round_q      <= 4'd0;
      key_q        <= '0;
      en_wr        <= 1'b0;
      addr_wr      <= 5'd0;
      key_round_wr <= '0;
      key_busy     <= 1'b0;
      key_done     <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      key_q        <= key_d;
      en_wr        <= en_wr_d;
      addr_wr      <= addr_wr_d;
      key_round_wr <= key_round_wr_d;
      key_busy     <= key_busy_d;
      key_done     <= key_done_d;
    end
  end

endmodule

// File: tb/tb_aes_128_key_expand.sv
module tb_aes_128_key_expand;

  logic         clk = 1'b0;
  logic         kill;
  logic         key_start;
  logic [127:0] key_in;
  logic         en_wr;
  logic [4:0]   addr_wr;
  logic [63:0]  key_round_wr;
  logic         key_busy;
  logic         key_done;

  always #5 clk = ~clk;

  aes_128_key_expand dut (
    .clk          (clk),
    .kill         (kill),
    .key_start    (key_start),
    .key_in       (key_in),
    .en_wr        (en_wr),
    .addr_wr      (addr_wr),
    .key_round_wr (key_round_wr),
    .key_busy     (key_busy),
    .key_done     (key_done)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  logic [7:0]  sbox_m [256];
  logic [63:0] exp_w [2][22];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 key expansion on a byte array; fills exp_w[slot] in RAM word order.
  task automatic model_expand(input logic [127:0] key, input int slot);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i / 4][i % 4] = key[8 * i +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i - 1][j];
      if (i % 4 == 0) begin
        t[0] = sbox_m[w[i - 1][1]] ^ rc;
        t[1] = sbox_m[w[i - 1][2]];
        t[2] = sbox_m[w[i - 1][3]];
        t[3] = sbox_m[w[i - 1][0]];
        rc   = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i - 4][j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int b = 0; b < 16; b++)
        exp_w[slot][2 * r + b / 8][8 * (b % 8) +: 8] = w[4 * r + b / 4][b % 4];
  endtask

  // Expected write schedule relative to the accepting cycle 0.
  function automatic logic exp_wr(input int c);
    return (c >= 1 && c <= 32 && (c % 3) != 0);
  endfunction

  function automatic logic [4:0] exp_adr(input int c);
    return 5'(2 * ((c - 1) / 3) + (((c % 3) == 2) ? 1 : 0));
  endfunction

  // ---------------- stimulus / capture ----------------
  logic        obs_en   [80];
  logic        obs_busy [80];
  logic        obs_done [80];
  logic [4:0]  obs_addr [80];
  logic [63:0] obs_data [80];

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cycle 0 presents key_start with key; outputs of cycle c land in obs_*[c].
  task automatic run_cycles(input logic [127:0] key, input int ncyc, input int kill_at,
                            input bit noisy, input bit chain, input logic [127:0] chain_key);
    for (int c = 0; c < ncyc; c++) begin
      kill      = (c == kill_at);
      key_start = (c == 0) || (noisy && (c == 5 || c == 20)) || (chain && c == 33);
      if (c == 0) key_in = key;
      else if (chain && c == 33) key_in = chain_key;
      else key_in = rand_key();
      @(posedge clk);
      #1;
      obs_en[c + 1]   = en_wr;
      obs_busy[c + 1] = key_busy;
      obs_done[c + 1] = key_done;
      obs_addr[c + 1] = addr_wr;
      obs_data[c + 1] = key_round_wr;
    end
    kill      = 1'b0;
    key_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    kill      = 1'b1;
    key_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_in = rand_key();
      @(posedge clk);
      #1;
      checks++;
      if ({en_wr, addr_wr, key_round_wr, key_busy, key_done} !== 72'd0)
        $display("FAIL reset cyc=%0d got en=%b addr=%0d data=%h busy=%b done=%b exp all 0",
                 i, en_wr, addr_wr, key_round_wr, key_busy, key_done);
    end
    kill      = 1'b0;
    key_start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({en_wr, key_busy, key_done} !== 3'b000)
      $display("FAIL reset_idle got en=%b busy=%b done=%b exp 000", en_wr, key_busy, key_done);
  endtask

  task automatic test_fips_vector();
    logic [127:0] key = 128'h0f0e0d0c0b0a09080706050403020100;
    model_expand(key, 0);
    run_cycles(key, 34, -1, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 33; c++) begin
      checks++;
      if (obs_en[c] !== exp_wr(c) ||
          (exp_wr(c) && (obs_addr[c] !== exp_adr(c) || obs_data[c] !== exp_w[0][exp_adr(c)]))) begin
        errors++;
        $display("FAIL fips_wr c=%0d got en=%b addr=%0d data=%h exp en=%b addr=%0d data=%h", c,
                 obs_en[c], obs_addr[c], obs_data[c], exp_wr(c), exp_adr(c), exp_w[0][exp_adr(c)]);
      end
      checks++;
      if ({obs_busy[c], obs_done[c]} !== {c <= 32, c == 33}) begin
        errors++;
        $display("FAIL fips_flags c=%0d got busy=%b done=%b exp busy=%b done=%b", c,
                 obs_busy[c], obs_done[c], c <= 32, c == 33);
      end
    end
    checks++;
    if (obs_data[1] !== 64'h0706050403020100) begin
      errors++; $display("FAIL fips_addr0 got=%h exp=0706050403020100", obs_data[1]);
    end
    checks++;
    if (obs_data[2] !== 64'h0f0e0d0c0b0a0908) begin
      errors++; $display("FAIL fips_addr1 got=%h exp=0f0e0d0c0b0a0908", obs_data[2]);
    end
    checks++;
    if (obs_data[4] !== 64'hfa72afd2fd74aad6) begin
      errors++; $display("FAIL fips_addr2 got=%h exp=fa72afd2fd74aad6", obs_data[4]);
    end
    checks++;
    if (obs_addr[32] !== 5'd21 || obs_data[32] !== 64'hc5302b4d8ba707f3) begin
      errors++;
      $display("FAIL fips_addr21 got addr=%0d data=%h exp addr=21 data=c5302b4d8ba707f3",
               obs_addr[32], obs_data[32]);
    end
  endtask

  task automatic test_zero_key();
    model_expand('0, 0);
    run_cycles('0, 34, -1, 1'b0, 1'b0, '0);
    checks++;
    if (obs_addr[4] !== 5'd2 || obs_data[4] !== 64'h6363636263636362) begin
      errors++;
      $display("FAIL zero_addr2 got addr=%0d data=%h exp addr=2 data=6363636263636362",
               obs_addr[4], obs_data[4]);
    end
    checks++;
    if (obs_addr[31] !== 5'd20 || obs_data[31] !== 64'h11e2923ecb5befb4) begin
      errors++;
      $display("FAIL zero_addr20 got addr=%0d data=%h exp addr=20 data=11e2923ecb5befb4",
               obs_addr[31], obs_data[31]);
    end
    for (int c = 1; c <= 32; c++) begin
      if (exp_wr(c)) begin
        checks++;
        if (obs_data[c] !== exp_w[0][exp_adr(c)]) begin
          errors++;
          $display("FAIL zero_word c=%0d got=%h exp=%h", c, obs_data[c], exp_w[0][exp_adr(c)]);
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    logic [127:0] key = 128'h0f0e0d0c0b0a09080706050403020100;
    model_expand(key, 0);
    run_cycles(key, 34, -1, 1'b1, 1'b0, '0);
    for (int c = 1; c <= 33; c++) begin
      checks++;
      if (obs_en[c] !== exp_wr(c) || obs_done[c] !== (c == 33) ||
          (exp_wr(c) && (obs_addr[c] !== exp_adr(c) || obs_data[c] !== exp_w[0][exp_adr(c)]))) begin
        errors++;
        $display("FAIL ignore_start c=%0d got en=%b addr=%0d data=%h done=%b exp en=%b addr=%0d data=%h",
                 c, obs_en[c], obs_addr[c], obs_data[c], obs_done[c], exp_wr(c), exp_adr(c),
                 exp_w[0][exp_adr(c)]);
      end
    end
  endtask

  task automatic test_kill();
    logic [127:0] key = rand_key();
    int nwr = 0;
    model_expand(key, 0);
    run_cycles(key, 16, 10, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 16; c++) begin
      if (obs_en[c] === 1'b1) nwr++;
      if (c > 10) begin
        checks++;
        if ({obs_en[c], obs_addr[c], obs_data[c], obs_busy[c], obs_done[c]} !== 72'd0) begin
          errors++;
          $display("FAIL kill_quiet c=%0d got en=%b addr=%0d data=%h busy=%b done=%b exp all 0",
                   c, obs_en[c], obs_addr[c], obs_data[c], obs_busy[c], obs_done[c]);
        end
      end
    end
    checks++;
    if (nwr != 7) begin
      errors++; $display("FAIL kill_writes got=%0d exp=7", nwr);
    end
    key = rand_key();
    model_expand(key, 0);
    run_cycles(key, 34, -1, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 33; c++) begin
      checks++;
      if (obs_en[c] !== exp_wr(c) || obs_done[c] !== (c == 33) ||
          (exp_wr(c) && (obs_addr[c] !== exp_adr(c) || obs_data[c] !== exp_w[0][exp_adr(c)]))) begin
        errors++;
        $display("FAIL kill_rerun c=%0d got en=%b addr=%0d data=%h exp en=%b addr=%0d data=%h", c,
                 obs_en[c], obs_addr[c], obs_data[c], exp_wr(c), exp_adr(c), exp_w[0][exp_adr(c)]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] key_a = rand_key();
    logic [127:0] key_b = rand_key();
    model_expand(key_a, 0);
    model_expand(key_b, 1);
    run_cycles(key_a, 67, -1, 1'b0, 1'b1, key_b);
    for (int c = 1; c <= 66; c++) begin
      int s   = (c <= 33) ? 0 : 1;
      int rel = (c <= 33) ? c : c - 33;
      checks++;
      if (obs_en[c] !== exp_wr(rel) || obs_done[c] !== (rel == 33) ||
          obs_busy[c] !== (rel <= 32) ||
          (exp_wr(rel) && (obs_addr[c] !== exp_adr(rel) ||
                           obs_data[c] !== exp_w[s][exp_adr(rel)]))) begin
        errors++;
        $display("FAIL b2b c=%0d got en=%b addr=%0d data=%h busy=%b done=%b exp en=%b addr=%0d data=%h",
                 c, obs_en[c], obs_addr[c], obs_data[c], obs_busy[c], obs_done[c], exp_wr(rel),
                 exp_adr(rel), exp_w[s][exp_adr(rel)]);
      end
    end
  endtask

  task automatic test_random_keys();
    for (int k = 0; k < 4; k++) begin
      logic [127:0] key = rand_key();
      logic [63:0]  got [22];
      model_expand(key, 0);
      run_cycles(key, 34, -1, 1'b0, 1'b0, '0);
      for (int a = 0; a < 22; a++) got[a] = 64'hx;
      for (int c = 1; c <= 33; c++)
        if (obs_en[c] === 1'b1 && obs_addr[c] < 5'd22) got[obs_addr[c]] = obs_data[c];
      for (int a = 0; a < 22; a++) begin
        checks++;
        if (got[a] !== exp_w[0][a]) begin
          errors++;
          $display("FAIL random_word key=%0d addr=%0d got=%h exp=%h", k, a, got[a], exp_w[0][a]);
        end
      end
    end
  endtask

  initial begin
    kill      = 1'b1;
    key_start = 1'b0;
    key_in    = '0;
    build_sbox();
    test_reset();
    test_fips_vector();
    test_zero_key();
    test_ignored_start();
    test_kill();
    test_back_to_back();
    test_random_keys();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
